pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Fetch-stage program counter with integrated next-PC selection, parametrised in address width, reset/exception vectors and return-address-stack (RAS) depth.
- Owns the PC register.
- Takes redirect commands decoded from the instruction in decode, plus exception/ERET requests from the CP0 path.
- Adds stall hold and a circular RAS that predicts return targets for jr $ra. Feeds the instruction memory address and the F/D pipeline register.

Parameters:
WIDTH, 32, PC/address width; must be >= 29
RESET_PC, 32'h0000_3000, PC value while/after reset (truncated to WIDTH)
EXC_VECTOR, 32'h0000_4180, exception handler entry (truncated to WIDTH)
RAS_DEPTH, 4, RAS entries; power of two, 2..16

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  hold PC and RAS this cycle
pc_op  in  3  redirect command for the instruction in decode (encoding below)
imm26  in  26  instr[25:0] of the decode instruction
pc_d  in  WIDTH  PC of the decode instruction
jr_target  in  WIDTH  forwarded rs value
cond  in  1  branch condition result (already evaluated)
exc_req  in  1  take exception
eret  in  1  return from exception
epc_in  in  WIDTH  EPC value from CP0
pc  out  WIDTH  current fetch PC
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_miss  out  1  registered 1-cycle pulse: JRRA target mispredicted

Behaviour:
- Reset (async): pc=RESET_PC, ras_count=0, ras_miss=0, RAS storage and pointer cleared. Deassertion is not required to be synchronous; first fetch is RESET_PC.
- Derived values: pc4d=pc_d+4. Jump target jt={pc4d[WIDTH-1:28],imm26,2'b00}. Branch target bt=pc4d+({{(WIDTH-18){imm26[15]}},imm26[15:0],2'b00}). All sums are modulo 2^WIDTH.
- pc_op encoding:
  - 0 SEQ: pc+4
  - 1 J: jt
  - 2 JAL: jt, and push pc_d+8
  - 3 JR: jr_target
  - 4 BR: bt if cond, else pc+4
  - 5 JRRA: pop. Target is jr_target (architectural), never the RAS value. If ras_count==0 or popped value != jr_target, ras_miss=1 next cycle.
  - 6, 7: treated as SEQ
- Priority per cycle, highest first:
  1. exc_req: pc<=EXC_VECTOR.
  2. eret: pc<=epc_in.
  3. stall: pc, RAS and ras_count hold.
  4. pc_op action.
  For 1 and 2, the RAS does not change, ras_miss=0 and stall is ignored.
- Latency: pc updates on the clock edge after the command; redirect visible one cycle later. No combinational path from any input to pc.
- ras_miss: registered, 1 cycle only. It is 0 in any cycle where the previous edge was not an un-stalled, non-exception JRRA.
- RAS is a circular LIFO with a top pointer.
  - Push when full: overwrite the oldest entry; ras_count stays RAS_DEPTH.
  - Pop when empty: no pointer change, count stays 0, miss flagged.
  - Push and pop never coincide, since one op per cycle.
- Words are word-aligned; pc[1:0] is whatever the inputs imply (no alignment check here).

Test Plan:
- Reset mid-run: pc at 0x3010, assert reset asynchronously between edges -> pc=0x3000 immediately, ras_count=0. Release -> next edges give 0x3004, 0x3008.
- Jump/branch: pc_d=0x3000, imm26=0x0000C05 with J -> pc=0x0000_3014. BR with imm16=0xFFFF, cond=1 -> pc=0x3000. Same with cond=0 -> pc=prev+4.
- Stall vs priority: stall=1 with pc_op=J -> pc unchanged. stall=1 with exc_req=1 -> pc=0x4180. exc_req and eret both high -> 0x4180. eret alone with epc_in=0x3020 -> pc=0x3020.
- RAS hit: JAL at pc_d=0x3000 (push 0x3008), later JRRA with jr_target=0x3008 -> pc=0x3008, ras_miss=0, ras_count 1->0.
- RAS overflow/underflow, RAS_DEPTH=4: five JALs push A..E -> count=4. Four JRRAs with jr_target E,D,C,B -> no miss. Fifth JRRA (target A) -> ras_miss=1 for exactly one cycle, count stays 0.
- Width sweep, WIDTH=30: same jump test -> upper bits taken from pc4d[29:28], sums wrap at 2^30 (pc 0x3FFF_FFFC + 4 -> 0).

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with next-PC selection, exception /
// ERET redirect, stall hold and a circular return-address stack that
// predicts the target of "jr $ra" and reports mispredictions.
module pc_gen #(
   parameter int unsigned WIDTH      = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter int unsigned RAS_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [2:0]                   pc_op,
   input  logic [25:0]                  imm26,
   input  logic [WIDTH-1:0]             pc_d,
   input  logic [WIDTH-1:0]             jr_target,
   input  logic                         cond,
   input  logic                         exc_req,
   input  logic                         eret,
   input  logic [WIDTH-1:0]             epc_in,
   output logic [WIDTH-1:0]             pc,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_miss
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [WIDTH-1:0] RST_PC    = WIDTH'(RESET_PC);
   localparam logic [WIDTH-1:0] EXC_PC    = WIDTH'(EXC_VECTOR);
   localparam logic [WIDTH-1:0] FOUR      = WIDTH'(4);
   localparam logic [WIDTH-1:0] EIGHT     = WIDTH'(8);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

   typedef enum logic [2:0] {
      OP_SEQ  = 3'd0,
      OP_J    = 3'd1,
      OP_JAL  = 3'd2,
      OP_JR   = 3'd3,
      OP_BR   = 3'd4,
      OP_JRRA = 3'd5
   } pc_op_e;

   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
   logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
   logic [PTR_W-1:0] ras_top_q, ras_top_d;   // next free slot
   logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
   logic             ras_miss_q, ras_miss_d;

   logic [WIDTH-1:0] pc4, pc4d, pc8d, jt, br_off, bt, ras_top_val;
   logic [PTR_W-1:0] top_m1;

   // Redirect target arithmetic, all modulo 2^WIDTH.
   always_comb begin
      pc4         = fetch_pc_q + FOUR;
      pc4d        = pc_d + FOUR;
      pc8d        = pc_d + EIGHT;
      jt          = {pc4d[WIDTH-1:28], imm26, 2'b00};
      br_off      = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
      bt          = pc4d + br_off;
      top_m1      = ras_top_q - PTR_ONE;
      ras_top_val = ras_mem_q[top_m1];
   end

   // Next PC and RAS update: exception > eret > stall > pc_op.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      ras_mem_d  = ras_mem_q;
      ras_top_d  = ras_top_q;
      ras_cnt_d  = ras_cnt_q;
      ras_miss_d = 1'b0;
      if (exc_req) begin
         fetch_pc_d = EXC_PC;
      end else if (eret) begin
         fetch_pc_d = epc_in;
      end else if (stall) begin
         fetch_pc_d = fetch_pc_q;
      end else begin
         case (pc_op)
            OP_J: begin
               fetch_pc_d = jt;
            end
            OP_JAL: begin
               fetch_pc_d           = jt;
               // Pointer wraps, so a push on a full stack overwrites the oldest entry.
               ras_mem_d[ras_top_q] = pc8d;
               ras_top_d            = ras_top_q + PTR_ONE;
               if (ras_cnt_q == CNT_FULL) begin
                  ras_cnt_d = ras_cnt_q;
               end else begin
                  ras_cnt_d = ras_cnt_q + CNT_ONE;
               end
            end
            OP_JR: begin
               fetch_pc_d = jr_target;
            end
            OP_BR: begin
               if (cond) begin
                  fetch_pc_d = bt;
               end else begin
                  fetch_pc_d = pc4;
               end
            end
            OP_JRRA: begin
               // The architectural target always wins; the RAS only grades itself.
               fetch_pc_d = jr_target;
               if (ras_cnt_q == CNT_ZERO) begin
                  ras_miss_d = 1'b1;
               end else begin
                  ras_top_d  = top_m1;
                  ras_cnt_d  = ras_cnt_q - CNT_ONE;
                  ras_miss_d = (ras_top_val != jr_target);
               end
            end
            default: begin
               fetch_pc_d = pc4;
            end
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RST_PC;
         ras_top_q  <= {PTR_W{1'b0}};
         ras_cnt_q  <= {CNT_W{1'b0}};
         ras_miss_q <= 1'b0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         ras_top_q  <= ras_top_d;
         ras_cnt_q  <= ras_cnt_d;
         ras_miss_q <= ras_miss_d;
         ras_mem_q  <= ras_mem_d;
      end
   end

   assign pc        = fetch_pc_q;
   assign ras_count = ras_cnt_q;
   assign ras_miss  = ras_miss_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (WIDTH=32 and WIDTH=30 instances).
module tb_pc_gen;

   logic        clk;
   logic        reset;
   logic        stall, cond, exc_req, eret;
   logic [2:0]  pc_op;
   logic [25:0] imm26;
   logic [31:0] pcd, jr_target, epc_in;
   logic [31:0] pc;
   logic [2:0]  ras_count;
   logic        ras_miss;

   logic [2:0]  w_op;
   logic [25:0] w_imm;
   logic [29:0] w_pcd, w_epc, w_pc;
   logic        w_cond, w_eret;
   logic [2:0]  w_cnt;
   logic        w_miss;

   int errors = 0;
   int checks = 0;

   pc_gen #(.WIDTH(32), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .imm26(imm26),
      .pc_d(pcd), .jr_target(jr_target), .cond(cond), .exc_req(exc_req),
      .eret(eret), .epc_in(epc_in), .pc(pc), .ras_count(ras_count),
      .ras_miss(ras_miss)
   );

   pc_gen #(.WIDTH(30), .RAS_DEPTH(4)) dut30 (
      .clk(clk), .reset(reset), .stall(1'b0), .pc_op(w_op), .imm26(w_imm),
      .pc_d(w_pcd), .jr_target(30'h0000_0000), .cond(w_cond), .exc_req(1'b0),
      .eret(w_eret), .epc_in(w_epc), .pc(w_pc), .ras_count(w_cnt),
      .ras_miss(w_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [2:0] o, input logic [31:0] p, input logic [25:0] im);
      pc_op = o;
      pcd   = p;
      imm26 = im;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; cond = 1'b0; exc_req = 1'b0; eret = 1'b0;
      pc_op = 3'd0; imm26 = 26'd0; pcd = 32'd0; jr_target = 32'd0; epc_in = 32'd0;
      w_op = 3'd0; w_imm = 26'd0; w_pcd = 30'd0; w_epc = 30'd0; w_cond = 1'b0; w_eret = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_cnt", {29'd0, ras_count}, 32'd0);
      chk("rst_miss", {31'd0, ras_miss}, 32'd0);
      chk("rst_pc30", {2'b00, w_pc}, 32'h0000_3000);
      tick();
      chk("rst_hold", pc, 32'h0000_3000);
      reset = 1'b0;
      tick();
      chk("seq1", pc, 32'h0000_3004);

      // JAL to 0x3010 so the RAS is non-empty before the mid-run reset.
      op(3'd2, 32'h0000_3000, 26'h000_0C04);
      tick();
      chk("jal_pc", pc, 32'h0000_3010);
      chk("jal_cnt", {29'd0, ras_count}, 32'd1);
      op(3'd0, 32'h0000_0000, 26'h0);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_pc", pc, 32'h0000_3000);
      chk("async_rst_cnt", {29'd0, ras_count}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_held_edge", pc, 32'h0000_3000);
      tick();
      chk("post_rst1", pc, 32'h0000_3004);
      tick();
      chk("post_rst2", pc, 32'h0000_3008);

      // Jump and branch targets.
      op(3'd1, 32'h0000_3000, 26'h000_0C05);
      tick();
      chk("j_target", pc, 32'h0000_3014);
      op(3'd4, 32'h0000_3000, 26'h000_FFFF); cond = 1'b1;
      tick();
      chk("br_taken", pc, 32'h0000_3000);
      cond = 1'b0;
      tick();
      chk("br_not_taken", pc, 32'h0000_3004);

      // Stall and redirect priority.
      op(3'd1, 32'h0000_3000, 26'h000_0C05); stall = 1'b1;
      tick();
      chk("stall_hold", pc, 32'h0000_3004);
      exc_req = 1'b1;
      tick();
      chk("exc_over_stall", pc, 32'h0000_4180);
      stall = 1'b0; eret = 1'b1; epc_in = 32'h0000_3020;
      tick();
      chk("exc_over_eret", pc, 32'h0000_4180);
      exc_req = 1'b0;
      tick();
      chk("eret", pc, 32'h0000_3020);
      eret = 1'b0;
      op(3'd3, 32'h0, 26'h0); jr_target = 32'h0000_5000;
      tick();
      chk("jr", pc, 32'h0000_5000);
      op(3'd6, 32'h0, 26'h0);
      tick();
      chk("op6_seq", pc, 32'h0000_5004);

      // RAS hit.
      op(3'd2, 32'h0000_3000, 26'h000_0C05);
      tick();
      chk("hit_jal_cnt", {29'd0, ras_count}, 32'd1);
      op(3'd5, 32'h0, 26'h0); jr_target = 32'h0000_3008;
      tick();
      chk("hit_pc", pc, 32'h0000_3008);
      chk("hit_miss", {31'd0, ras_miss}, 32'd0);
      chk("hit_cnt", {29'd0, ras_count}, 32'd0);

      // RAS value mismatch.
      op(3'd2, 32'h0000_3100, 26'h000_0C05);
      tick();
      op(3'd5, 32'h0, 26'h0); jr_target = 32'h0000_3200;
      tick();
      chk("mis_pc", pc, 32'h0000_3200);
      chk("mis_flag", {31'd0, ras_miss}, 32'd1);
      chk("mis_cnt", {29'd0, ras_count}, 32'd0);
      stall = 1'b1;
      tick();
      chk("mis_stall_clear", {31'd0, ras_miss}, 32'd0);
      chk("mis_stall_pc", pc, 32'h0000_3200);
      op(3'd2, 32'h0000_3000, 26'h000_0C05);
      tick();
      chk("stall_jal_cnt", {29'd0, ras_count}, 32'd0);
      stall = 1'b0; exc_req = 1'b1;
      tick();
      chk("exc_jal_cnt", {29'd0, ras_count}, 32'd0);
      chk("exc_jal_pc", pc, 32'h0000_4180);
      exc_req = 1'b0;

      // Overflow: five pushes of 0x1008..0x5008 into four entries.
      for (int i = 1; i <= 5; i++) begin
         op(3'd2, 32'h0000_1000 * i, 26'h000_0C05);
         tick();
      end
      chk("ovf_cnt", {29'd0, ras_count}, 32'd4);
      for (int i = 5; i >= 2; i--) begin
         op(3'd5, 32'h0, 26'h0); jr_target = 32'h0000_1008 + 32'h0000_1000 * (i - 1);
         tick();
         chk("pop_miss", {31'd0, ras_miss}, 32'd0);
         chk("pop_cnt", {29'd0, ras_count}, i - 2);
      end
      jr_target = 32'h0000_1008;
      tick();
      chk("under_pc", pc, 32'h0000_1008);
      chk("under_miss", {31'd0, ras_miss}, 32'd1);
      chk("under_cnt", {29'd0, ras_count}, 32'd0);
      op(3'd0, 32'h0, 26'h0);
      tick();
      chk("under_pulse_end", {31'd0, ras_miss}, 32'd0);
      chk("under_seq", pc, 32'h0000_100C);

      // WIDTH=30 instance: wrap and upper jump bits.
      w_eret = 1'b1; w_epc = 30'h3FFF_FFFC;
      tick();
      chk("w30_eret", {2'b00, w_pc}, 32'h3FFF_FFFC);
      w_eret = 1'b0; w_op = 3'd0;
      tick();
      chk("w30_wrap", {2'b00, w_pc}, 32'h0000_0000);
      w_op = 3'd1; w_pcd = 30'h3FFF_FFF0; w_imm = 26'h000_0C05;
      tick();
      chk("w30_jump", {2'b00, w_pc}, 32'h3000_3014);
      w_op = 3'd4; w_pcd = 30'h3FFF_FFFC; w_imm = 26'h000_0004; w_cond = 1'b1;
      tick();
      chk("w30_br_wrap", {2'b00, w_pc}, 32'h0000_0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
